pe_psum_drain: RTL and testbench
================================

Name: pe_psum_drain

Overview:
- Sits directly downstream of the PE's POUT port and consumes the PEROW-wide partial-sum vectors the PE emits through the POUT rdy/ack handshake.
- Buffers whole vectors in a small FIFO and serializes each one into OLANES-wide beats on a narrower OUT rdy/ack port that feeds the column output bus / GLB writer.
- Decouples PE pipeline stalls from output-bus backpressure.

Parameters:
- PEROW, 16, psum lanes per input vector; must be a multiple of OLANES.
- PSUMDWD, 16, bits per psum lane, two's complement.
- OLANES, 4, lanes per output beat.
- DEPTH, 4, FIFO depth in whole vectors; power of two, >= 2.
- CNTWD, 16, width of the drained-vector counter.

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, synchronous active-high reset.
- POUT_rdy, input, 1, PE has a valid psum vector.
- POUT_ack, output, 1, drain accepts the vector.
- i_Psum, input, PSUMDWD x PEROW (unpacked [PEROW]), psum vector from the PE.
- OUT_rdy, output, 1, valid output beat present.
- OUT_ack, input, 1, downstream accepts the beat.
- o_data, output, PSUMDWD x OLANES (unpacked [OLANES]), current beat lanes.
- o_beat, output, $clog2(PEROW/OLANES) (min 1), beat index within the vector; lane k of beat b is row b*OLANES+k.
- o_last, output, 1, current beat is the final beat of its vector.
- o_vec_cnt, output, CNTWD, count of fully drained vectors.

Behaviour:
- Reset is synchronous to i_clk and active-high, applied while i_rst=1. It clears the write pointer, read pointer, occupancy count, beat counter and o_vec_cnt to 0. FIFO storage is not cleared.
- Output values during reset and on the cycle after: POUT_ack=0 while i_rst=1; OUT_rdy=0; o_data all 0; o_beat=0; o_last=0; o_vec_cnt=0.
- Handshake: a transfer occurs on a rising edge where rdy=1 and ack=1. rdy, once raised, holds with stable data until acked; the bench checks this on the OUT side.
- POUT_ack = !full && !i_rst. It depends only on registered state, never on POUT_rdy or OUT_ack.
- Push on an input transfer: write i_Psum to mem[wptr]; wptr wraps at DEPTH; count+1.
- OUT_rdy = !empty. It is driven from registered state only.
- o_data lanes = mem[rptr] rows [beat*OLANES +: OLANES]. All lanes are forced to 0 when OUT_rdy=0.
- o_last = OUT_rdy && (beat == PEROW/OLANES-1).
- Output transfer on a non-last beat: beat+1.
- Output transfer on the last beat:
  - beat resets to 0 and the FIFO pops (rptr wraps at DEPTH; count-1).
  - o_vec_cnt increments by 1 and wraps modulo 2^CNTWD.
- Serializer state machine, derived from count and beat:
  - IDLE (empty): go to STREAM on push.
  - STREAM: return to IDLE on the last-beat pop when count becomes 0; otherwise stay in STREAM with the next head vector and beat=0.
- Latency: a vector accepted at edge t with the FIFO empty drives OUT_rdy=1 with beat 0 in the cycle after t. There is no fall-through within the same cycle.
- Throughput: one beat per cycle when OUT_ack is held at 1. Back-to-back vectors stream with no bubble.
- Simultaneous push and pop (count not full): both take effect; count is unchanged.
- Full: POUT_ack=0 even if a pop occurs in the same cycle, so the push is deferred one cycle. No overwrite is ever possible.
- Empty with OUT_ack=1: no effect.
- Reset mid-vector: partial beats are abandoned and all buffered vectors are discarded. The first post-reset output is beat 0 of the next pushed vector.
- Width rules: no arithmetic on the data path except the optional clamp; lanes pass bit-exact.

Optional Feature:
- Macro: PSUM_DRAIN_RELU_EN.
- Defined: each lane is clamped at the push, before storage. A lane with its MSB set is stored as 0; other values are unchanged. The clamp adds no latency.
- Not defined: lanes are stored bit-exact, and negative psums pass through unchanged.

Test Plan:
- Single vector, rows 0..15 = 0x0100+row, OUT_ack=1 -> 4 beats on consecutive cycles starting one cycle after the push. Beat 2 = {0x0108,0x0109,0x010A,0x010B}. o_last is set only on beat 3. o_vec_cnt then reads 1.
- OUT_ack held at 0, 5 vectors offered -> POUT_ack drops after the 4th push and the 5th is held. Release OUT_ack=1 -> the 5th vector is accepted in the cycle after the first pop, and all 20 beats emerge in order.
- Continuous push with OUT_ack=1 -> OUT_rdy stays at 1 with no gaps between vectors, and count never exceeds 2.
- Random OUT_ack (50%) -> o_data, o_beat and o_last stay stable while OUT_rdy=1 and OUT_ack=0.
- i_rst for 1 cycle during beat 1 of vector 2 of 3 buffered -> next cycle OUT_rdy=0, o_vec_cnt=0, POUT_ack=1. A following push restarts at beat 0.
- With PSUM_DRAIN_RELU_EN defined, row 3 = 0xFFF0 and row 4 = 0x7FFF -> output 0x0000 and 0x7FFF. Without the macro -> 0xFFF0 and 0x7FFF.

Source files
------------

// File: rtl/pe_psum_drain.sv
// rtl/pe_psum_drain.sv - buffers PE psum vectors and serializes them into OLANES-wide output beats
// Optional clamp of negative lanes at push: define PSUM_DRAIN_RELU_EN.
module pe_psum_drain #(
  parameter int PEROW   = 16,
  parameter int PSUMDWD = 16,
  parameter int OLANES  = 4,
  parameter int DEPTH   = 4,
  parameter int CNTWD   = 16,
  localparam int BEATS  = PEROW / OLANES,
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               POUT_rdy,
  output logic               POUT_ack,
  input  logic [PSUMDWD-1:0] i_Psum [PEROW],
  output logic               OUT_rdy,
  input  logic               OUT_ack,
  output logic [PSUMDWD-1:0] o_data [OLANES],
  output logic [BW-1:0]      o_beat,
  output logic               o_last,
  output logic [CNTWD-1:0]   o_vec_cnt
);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [CNTWD-1:0]   vec_cnt_q, vec_cnt_d;

  logic [PSUMDWD-1:0] mem [DEPTH][PEROW];
  logic [PSUMDWD-1:0] wr_vec [PEROW];

  logic full;
  logic push;
  logic beat_xfer;
  logic last_beat;
  logic pop;

  // Acceptance looks only at registered occupancy, so a pop cannot free a slot in the same cycle.
  assign full      = (count_q == CW'(DEPTH));
  assign POUT_ack  = !full && !i_rst;
  assign push      = POUT_rdy && POUT_ack;

  assign OUT_rdy   = (state_q == S_STREAM);
  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign o_last    = OUT_rdy && last_beat;
  assign beat_xfer = OUT_rdy && OUT_ack;
  assign pop       = beat_xfer && last_beat;

  assign o_beat    = beat_q;
  assign o_vec_cnt = vec_cnt_q;

  always_comb begin
    for (int r = 0; r < PEROW; r++) begin
`ifdef PSUM_DRAIN_RELU_EN
      wr_vec[r] = i_Psum[r][PSUMDWD-1] ? '0 : i_Psum[r];
`else
      wr_vec[r] = i_Psum[r];
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    beat_d    = beat_q;
    vec_cnt_d = vec_cnt_q;

    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end

    if (beat_xfer) begin
      if (last_beat) begin
        beat_d    = '0;
        rptr_d    = rptr_q + AW'(1);
        vec_cnt_d = vec_cnt_q + CNTWD'(1);
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (push) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (pop && (count_d == '0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      beat_q    <= '0;
      vec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      beat_q    <= beat_d;
      vec_cnt_q <= vec_cnt_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      for (int r = 0; r < PEROW; r++) begin
        mem[wptr_q][r] <= wr_vec[r];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < OLANES; k++) begin
      o_data[k] = '0;
    end
    if (OUT_rdy) begin
      for (int b = 0; b < BEATS; b++) begin
        if (beat_q == BW'(b)) begin
          for (int k = 0; k < OLANES; k++) begin
            o_data[k] = mem[rptr_q][b*OLANES+k];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_psum_drain.sv
// tb/tb_pe_psum_drain.sv - self-checking bench for pe_psum_drain
`timescale 1ns/1ps
module tb_pe_psum_drain;
  localparam int PEROW   = 16;
  localparam int PSUMDWD = 16;
  localparam int OLANES  = 4;
  localparam int DEPTH   = 4;
  localparam int CNTWD   = 16;

  logic               clk = 1'b0;
  logic               i_rst;
  logic               pout_rdy;
  logic               pout_ack;
  logic [PSUMDWD-1:0] psum [PEROW];
  logic               out_rdy;
  logic               out_ack;
  logic [PSUMDWD-1:0] o_data [OLANES];
  logic [1:0]         o_beat;
  logic               o_last;
  logic [CNTWD-1:0]   o_vec_cnt;

  int tests = 0;
  int fails = 0;

  logic [PSUMDWD-1:0] exp_rows [$];
  int                 exp_beat   = 0;
  int                 model_vcnt = 0;
  logic               mon_en     = 1'b0;

  logic               hold_v = 1'b0;
  logic [PSUMDWD-1:0] hold_d [OLANES];
  logic [1:0]         hold_b;
  logic               hold_l;

  always #5 clk = ~clk;

  pe_psum_drain #(
    .PEROW  (PEROW),
    .PSUMDWD(PSUMDWD),
    .OLANES (OLANES),
    .DEPTH  (DEPTH),
    .CNTWD  (CNTWD)
  ) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .POUT_rdy (pout_rdy),
    .POUT_ack (pout_ack),
    .i_Psum   (psum),
    .OUT_rdy  (out_rdy),
    .OUT_ack  (out_ack),
    .o_data   (o_data),
    .o_beat   (o_beat),
    .o_last   (o_last),
    .o_vec_cnt(o_vec_cnt)
  );

  typedef struct {
    logic        rst;
    logic        prdy;
    logic [15:0] base;
    logic        oack;
    logic        e_ordy;
    logic [1:0]  e_beat;
    logic        e_last;
    logic [15:0] e_d0;
    logic        e_pack;
    logic [15:0] e_vcnt;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef PSUM_DRAIN_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [15:0] base);
    for (int r = 0; r < PEROW; r++) psum[r] = base + 16'(r);
  endtask

  task automatic push_cur();
    int   n   = 0;
    logic got = 1'b0;
    pout_rdy = 1'b1;
    while (!got && n < 50) begin
      @(negedge clk);
      got = pout_ack;
      tick();
      n++;
    end
    pout_rdy = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: POUT_ack stayed 0 for %0d cycles", n);
    end
  endtask

  task automatic push_vec(input logic [15:0] base);
    set_vec(base);
    push_cur();
  endtask

  task automatic drain_all();
    int n = 0;
    out_ack = 1'b1;
    while ((exp_rows.size() != 0 || out_rdy) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_idle", out_rdy, 0);
    chk("drain_model_empty", exp_rows.size(), 0);
    chk("drain_vcnt", o_vec_cnt, model_vcnt[15:0]);
  endtask

  // Scoreboard: expected beats in push order, plus hold-stability under backpressure.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !i_rst) begin
        if (hold_v) begin
          chk("hold_rdy", out_rdy, 1);
          chk("hold_beat", o_beat, hold_b);
          chk("hold_last", o_last, hold_l);
          for (int k = 0; k < OLANES; k++) chk("hold_data", o_data[k], hold_d[k]);
        end
        if (pout_rdy && pout_ack) begin
          for (int r = 0; r < PEROW; r++) exp_rows.push_back(relu(psum[r]));
        end
        if (out_rdy && out_ack) begin
          if (exp_rows.size() < OLANES) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: beat %0d data0 %0h with empty model", o_beat, o_data[0]);
          end else begin
            for (int k = 0; k < OLANES; k++) chk("beat_data", o_data[k], exp_rows.pop_front());
            chk("beat_idx", o_beat, exp_beat);
            chk("beat_last", o_last, exp_beat == 3);
            if (exp_beat == 3) begin
              exp_beat = 0;
              model_vcnt++;
            end else begin
              exp_beat++;
            end
          end
        end
        hold_v = out_rdy && !out_ack;
        hold_b = o_beat;
        hold_l = o_last;
        for (int k = 0; k < OLANES; k++) hold_d[k] = o_data[k];
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp3;

    //          rst prdy base      oack ordy beat last d0        pack vcnt
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 16'd0};
    tbl[2]  = '{1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 16'd0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0100, 1'b1, 1'b1, 2'd0, 1'b0, 16'h0100, 1'b1, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0100, 1'b1, 1'b1, 2'd1, 1'b0, 16'h0104, 1'b1, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 16'h0100, 1'b1, 1'b1, 2'd2, 1'b0, 16'h0108, 1'b1, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 16'h0100, 1'b1, 1'b1, 2'd3, 1'b1, 16'h010C, 1'b1, 16'd0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 16'd1};
    tbl[8]  = '{1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 16'd1};
    tbl[9]  = '{1'b0, 1'b0, 16'h0200, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0200, 1'b1, 16'd1};
    tbl[10] = '{1'b0, 1'b0, 16'h0200, 1'b1, 1'b1, 2'd0, 1'b0, 16'h0200, 1'b1, 16'd1};
    tbl[11] = '{1'b0, 1'b0, 16'h0200, 1'b1, 1'b1, 2'd1, 1'b0, 16'h0204, 1'b1, 16'd1};
    tbl[12] = '{1'b0, 1'b0, 16'h0200, 1'b1, 1'b1, 2'd2, 1'b0, 16'h0208, 1'b1, 16'd1};
    tbl[13] = '{1'b0, 1'b0, 16'h0200, 1'b1, 1'b1, 2'd3, 1'b1, 16'h020C, 1'b1, 16'd1};
    tbl[14] = '{1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 16'd2};

    i_rst    = 1'b1;
    pout_rdy = 1'b0;
    out_ack  = 1'b0;
    set_vec(16'h0000);
    repeat (3) tick();
    mon_en = 1'b1;

    // Reset values, single-vector latency/serialization, held beat under backpressure.
    for (int i = 0; i < 15; i++) begin
      i_rst    = tbl[i].rst;
      pout_rdy = tbl[i].prdy;
      out_ack  = tbl[i].oack;
      set_vec(tbl[i].base);
      if (tbl[i].rst) begin
        exp_rows.delete();
        exp_beat   = 0;
        model_vcnt = 0;
      end
      #1;
      chk("tbl_out_rdy", out_rdy, tbl[i].e_ordy);
      chk("tbl_beat", o_beat, tbl[i].e_beat);
      chk("tbl_last", o_last, tbl[i].e_last);
      chk("tbl_pout_ack", pout_ack, tbl[i].e_pack);
      chk("tbl_vec_cnt", o_vec_cnt, tbl[i].e_vcnt);
      for (int k = 0; k < OLANES; k++)
        chk("tbl_data", o_data[k], tbl[i].e_ordy ? tbl[i].e_d0 + 16'(k) : 16'h0000);
      tick();
    end
    pout_rdy = 1'b0;
    out_ack  = 1'b0;

    // Full FIFO: fifth vector held, accepted only in the cycle after the first pop.
    for (int v = 0; v < 4; v++) push_vec(16'h1000 + 16'(v) * 16'h0100);
    set_vec(16'h1400);
    pout_rdy = 1'b1;
    #1 chk("full_ack", pout_ack, 0);
    tick();
    chk("full_ack_hold", pout_ack, 0);
    out_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("full_ack_draining", pout_ack, 0);
      tick();
    end
    #1 chk("deferred_push_ack", pout_ack, 1);
    tick();
    pout_rdy = 1'b0;
    drain_all();
    chk("full_vcnt", o_vec_cnt, 7);

    // Random downstream backpressure.
    out_ack = 1'b0;
    fork
      begin
        for (int v = 0; v < 4; v++) push_vec(16'h3000 + 16'(v) * 16'h0111);
      end
      begin
        repeat (80) begin
          out_ack = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    drain_all();

    // Back-to-back vectors with simultaneous push/pop: no bubble.
    out_ack = 1'b1;
    push_vec(16'h5000);
    for (int c = 0; c < 16; c++) begin
      if (c % 4 == 3 && c < 12) begin
        set_vec(16'h5000 + 16'(c + 1) * 16'h0040);
        pout_rdy = 1'b1;
      end else begin
        pout_rdy = 1'b0;
      end
      #1;
      chk("stream_rdy", out_rdy, 1);
      chk("stream_pack", pout_ack, 1);
      tick();
    end
    pout_rdy = 1'b0;
    #1 chk("stream_end", out_rdy, 0);
    drain_all();

    // Reset during beat 1 of the second of three buffered vectors.
    out_ack = 1'b0;
    for (int v = 0; v < 3; v++) push_vec(16'h6000 + 16'(v) * 16'h0100);
    out_ack = 1'b1;
    repeat (5) tick();
    chk("pre_rst_beat", o_beat, 1);
    chk("pre_rst_data", o_data[0], 16'h6104);
    i_rst = 1'b1;
    exp_rows.delete();
    exp_beat   = 0;
    model_vcnt = 0;
    #1 chk("rst_pout_ack", pout_ack, 0);
    tick();
    i_rst   = 1'b0;
    out_ack = 1'b0;
    #1;
    chk("post_rst_rdy", out_rdy, 0);
    chk("post_rst_vcnt", o_vec_cnt, 0);
    chk("post_rst_pack", pout_ack, 1);
    chk("post_rst_data", o_data[0], 0);
    push_vec(16'h7000);
    chk("restart_rdy", out_rdy, 1);
    chk("restart_beat", o_beat, 0);
    chk("restart_data", o_data[0], 16'h7000);
    drain_all();
    chk("restart_vcnt", o_vec_cnt, 1);

    // Negative lane handling (clamped only with the optional feature).
    out_ack = 1'b0;
    set_vec(16'h0010);
    psum[3] = 16'hFFF0;
    psum[4] = 16'h7FFF;
`ifdef PSUM_DRAIN_RELU_EN
    exp3 = 16'h0000;
`else
    exp3 = 16'hFFF0;
`endif
    push_cur();
    chk("neg_row3", o_data[3], exp3);
    chk("neg_row2", o_data[2], 16'h0012);
    out_ack = 1'b1;
    tick();
    chk("pos_row4", o_data[0], 16'h7FFF);
    drain_all();
    chk("final_vcnt", o_vec_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
